// File: rtl/if_id_stage.sv
// if_id_stage: instruction register between fetch and decode.
// Two-entry skid FIFO of {pc, inst} with valid/ready on both sides and a
// synchronous flush. The head entry is split into MIPS instruction fields.
// in_ready depends only on the registered occupancy, so no combinational
// path exists from decode back to fetch.
// Optional feature macro: IFID_STALL_CNT_EN (decode-stall cycle counter).
module if_id_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm_16,
    output logic [25:0]       addr_26,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [31:0]     inst_q [2];
    logic [31:0]     inst_d [2];
    logic [PC_W-1:0] pc_q   [2];
    logic [PC_W-1:0] pc_d   [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            push_s, pop_s;

    // Handshake status comes only from the registered occupancy.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Next-state for storage, pointers and occupancy; flush overrides push/pop.
    always_comb begin
        inst_d[0] = inst_q[0];
        inst_d[1] = inst_q[1];
        pc_d[0]   = pc_q[0];
        pc_d[1]   = pc_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_s) begin
                inst_d[wr_ptr_q] = in_inst;
                pc_d[wr_ptr_q]   = in_pc;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q[0] <= 32'd0;
            inst_q[1] <= 32'd0;
            pc_q[0]   <= {PC_W{1'b0}};
            pc_q[1]   <= {PC_W{1'b0}};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            inst_q[0] <= inst_d[0];
            inst_q[1] <= inst_d[1];
            pc_q[0]   <= pc_d[0];
            pc_q[1]   <= pc_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Head data is forced to zero when the stage is empty.
    assign out_inst = out_valid ? inst_q[rd_ptr_q] : 32'd0;
    assign out_pc   = out_valid ? pc_q[rd_ptr_q]   : {PC_W{1'b0}};
    assign pc_plus4 = out_valid ? (out_pc + {{(PC_W-3){1'b0}}, 3'b100}) : {PC_W{1'b0}};

    // Field slices; zero whenever out_inst is zero.
    assign opcode  = out_inst[31:26];
    assign rs      = out_inst[25:21];
    assign rt      = out_inst[20:16];
    assign rd      = out_inst[15:11];
    assign shamt   = out_inst[10:6];
    assign funct   = out_inst[5:0];
    assign imm_16  = out_inst[15:0];
    assign addr_26 = out_inst[25:0];

`ifdef IFID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where decode holds off a valid head, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid & ~out_ready & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_stage;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic [31:0]       in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              in_ready, out_valid;
    logic [31:0]       out_inst;
    logic [PC_W-1:0]   out_pc, pc_plus4;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [15:0]       imm_16;
    logic [25:0]       addr_26;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of {pc, inst}, plus the stall count.
    logic [63:0]       m_q[$];
    int                m_stall;

    if_id_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .pc_plus4(pc_plus4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_16(imm_16), .addr_26(addr_26), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_all(input string tag);
        logic [31:0]     e_inst;
        logic [PC_W-1:0] e_pc, e_p4;
        logic [63:0]     e_stall;
        e_inst = 32'd0;
        e_pc   = {PC_W{1'b0}};
        e_p4   = {PC_W{1'b0}};
        if (m_q.size() != 0) begin
            e_inst = m_q[0][31:0];
            e_pc   = m_q[0][63:32];
            e_p4   = e_pc + 32'd4;
        end
`ifdef IFID_STALL_CNT_EN
        e_stall = 64'(m_stall);
`else
        e_stall = 64'd0;
`endif
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(m_q.size() != 2));
        check({tag, ".out_inst"},  64'(out_inst),  64'(e_inst));
        check({tag, ".out_pc"},    64'(out_pc),    64'(e_pc));
        check({tag, ".pc_plus4"},  64'(pc_plus4),  64'(e_p4));
        check({tag, ".fields"},
              {6'd0, opcode, rs, rt, rd, shamt, funct, imm_16, addr_26},
              {6'd0, e_inst[31:26], e_inst[25:21], e_inst[20:16], e_inst[15:11],
               e_inst[10:6], e_inst[5:0], e_inst[15:0], e_inst[25:0]});
        check({tag, ".stall_cnt"}, 64'(stall_cnt), e_stall);
    endtask

    // One clock cycle: drive inputs, advance model on the edge, then check.
    task automatic step(input string tag, input logic r, input logic f, input logic iv,
                        input logic [31:0] inst, input logic [PC_W-1:0] pc, input logic ordy);
        logic do_push, do_pop, stalled;
        rst = r; flush = f; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
        do_push = iv && (m_q.size() < 2);
        do_pop  = ordy && (m_q.size() > 0);
        stalled = !ordy && (m_q.size() > 0);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_stall = 0;
        end else begin
            if (stalled && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (f) m_q.delete();
            else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) m_q.push_back({pc, inst});
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        m_stall = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = {PC_W{1'b0}};

        // 1: reset for two cycles
        step("rst0", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step("rst1", 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1000, 1'b1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.imm_16", 64'(imm_16), 64'd0);

        // 2: single push, one-cycle latency, then empty
        step("lui", 1'b0, 1'b0, 1'b1, 32'h3C01ABCD, 32'h00400000, 1'b1);
        check("lui.opcode", 64'(opcode), 64'h0F);
        check("lui.rt", 64'(rt), 64'd1);
        check("lui.imm", 64'(imm_16), 64'hABCD);
        check("lui.pc4", 64'(pc_plus4), 64'h00400004);
        step("lui_pop", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("lui_pop.out_valid", 64'(out_valid), 64'd0);

        // 3: fill while decode stalls, third held off, drain in order
        step("fill1", 1'b0, 1'b0, 1'b1, 32'h11111111, 32'h100, 1'b0);
        step("fill2", 1'b0, 1'b0, 1'b1, 32'h22222222, 32'h104, 1'b0);
        check("fill2.in_ready", 64'(in_ready), 64'd0);
        step("fill3", 1'b0, 1'b0, 1'b1, 32'h33333333, 32'h108, 1'b0);
        check("fill3.head", 64'(out_inst), 64'h11111111);
        step("drain1", 1'b0, 1'b0, 1'b1, 32'h33333333, 32'h108, 1'b1);
        check("drain1.head", 64'(out_inst), 64'h22222222);
        step("drain2", 1'b0, 1'b0, 1'b1, 32'h33333333, 32'h108, 1'b1);
        check("drain2.head", 64'(out_inst), 64'h33333333);
        step("drain3", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("drain3.out_valid", 64'(out_valid), 64'd0);

        // 4: steady push+pop at count=1
        step("ss_fill", 1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h200, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step("ss", 1'b0, 1'b0, 1'b1, 32'hA0000000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1);
            check("ss.head", 64'(out_inst), 64'hA0000000 + 64'(i));
        end
        step("ss_end", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // pc_plus4 wrap at the top of the address space
        step("wrap", 1'b0, 1'b0, 1'b1, 32'h00000020, 32'hFFFFFFFC, 1'b0);
        check("wrap.pc4", 64'(pc_plus4), 64'd0);

        // 5: flush while full with an instruction on offer
        step("f_fill", 1'b0, 1'b0, 1'b1, 32'h44444444, 32'h300, 1'b0);
        step("flush", 1'b0, 1'b1, 1'b1, 32'h55555555, 32'h304, 1'b0);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        step("f_idle", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // 6: stall counter, flush keeps it, saturation
        step("s_rst", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step("s_push", 1'b0, 1'b0, 1'b1, 32'h66666666, 32'h400, 1'b0);
        for (int i = 0; i < 5; i++) step("stall", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`ifdef IFID_STALL_CNT_EN
        check("stall5", 64'(stall_cnt), 64'd5);
`else
        check("stall5", 64'(stall_cnt), 64'd0);
`endif
        step("s_flush", 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        step("s_push2", 1'b0, 1'b0, 1'b1, 32'h77777777, 32'h500, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`ifdef IFID_STALL_CNT_EN
        check("stall_sat", 64'(stall_cnt), 64'd15);
`else
        check("stall_sat", 64'(stall_cnt), 64'd0);
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 $urandom_range(0, 1) == 1, $urandom, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                 $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
